// File: rtl/logic_unit_pipe_if.sv
// Handshaked operand/result bundle for logic_unit_pipe.
// master = operand source / result consumer side, slave = the logic unit.
interface logic_unit_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             zero;
  logic             parity;
  logic             op_err;
  logic [15:0]      txn_count;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, y, zero, parity, op_err, txn_count
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, y, zero, parity, op_err, txn_count
  );
endinterface

// File: rtl/logic_unit_pipe.sv
// Pipelined WIDTH-bit bitwise logic unit with valid/ready backpressure.
// The function is evaluated at the input and the result plus flags travel
// through STAGES register stages; the last stage drives the outputs.
module logic_unit_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  logic_unit_pipe_if.slave  bus
);

  localparam int LAST = STAGES - 1;

  // Function result at the input, before stage 0
  logic [WIDTH-1:0] f_y;
  logic             f_err;
  logic             f_zero;
  logic             f_parity;

  // Stage registers
  logic [STAGES-1:0] valid_reg;
  logic [STAGES-1:0] zero_reg;
  logic [STAGES-1:0] parity_reg;
  logic [STAGES-1:0] err_reg;
  logic [WIDTH-1:0]  y_reg [STAGES];

  // Per-stage load enable and the value each stage would capture
  logic [STAGES-1:0] load;
  logic [STAGES-1:0] src_valid;
  logic [STAGES-1:0] src_zero;
  logic [STAGES-1:0] src_parity;
  logic [STAGES-1:0] src_err;
  logic [WIDTH-1:0]  src_y [STAGES];

  logic        accept;
  logic [15:0] txn_count_reg;

  // Decode the selected logic function; op 7 yields zero and raises op_err
  always_comb begin
    f_y   = '0;
    f_err = 1'b0;
    case (bus.op)
      3'd0:    f_y = bus.a & bus.b;
      3'd1:    f_y = bus.a | bus.b;
      3'd2:    f_y = ~bus.b;
      3'd3:    f_y = ~(bus.a & bus.b);
      3'd4:    f_y = ~(bus.a | bus.b);
      3'd5:    f_y = bus.a ^ bus.b;
      3'd6:    f_y = ~(bus.a ^ bus.b);
      default: f_err = 1'b1;
    endcase
  end

  assign f_zero   = ~|f_y;
  assign f_parity = ^f_y;

  // A stage can load when it, or any stage downstream of it, has a free
  // slot, or the consumer is taking the last result. Writing the chained
  // "empty or advancing" rule in this closed form keeps the ready path free
  // of self-referencing vector bits while staying bubble-free.
  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      assign load[gi] = bus.out_ready | ~(&valid_reg[LAST:gi]);

      if (gi == 0) begin : g_first
        assign src_valid[gi]  = bus.in_valid;
        assign src_y[gi]      = f_y;
        assign src_zero[gi]   = f_zero;
        assign src_parity[gi] = f_parity;
        assign src_err[gi]    = f_err;
      end else begin : g_next
        assign src_valid[gi]  = valid_reg[gi-1];
        assign src_y[gi]      = y_reg[gi-1];
        assign src_zero[gi]   = zero_reg[gi-1];
        assign src_parity[gi] = parity_reg[gi-1];
        assign src_err[gi]    = err_reg[gi-1];
      end
    end
  endgenerate

  assign bus.in_ready = ~rst & load[0];
  assign accept       = bus.in_valid & load[0];

  // Advance the stage chain; payload only moves with a valid transaction so
  // an emptied stage keeps stale data behind a cleared valid bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg  <= '0;
      zero_reg   <= '0;
      parity_reg <= '0;
      err_reg    <= '0;
      for (int k = 0; k < STAGES; k++) begin
        y_reg[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (load[k]) begin
          valid_reg[k] <= src_valid[k];
          if (src_valid[k]) begin
            y_reg[k]      <= src_y[k];
            zero_reg[k]   <= src_zero[k];
            parity_reg[k] <= src_parity[k];
            err_reg[k]    <= src_err[k];
          end
        end
      end
    end
  end

  // Count accepted transactions, saturating at all ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txn_count_reg <= '0;
    end else if (accept && (txn_count_reg != 16'hFFFF)) begin
      txn_count_reg <= txn_count_reg + 16'd1;
    end
  end

  assign bus.out_valid = valid_reg[LAST];
  assign bus.y         = y_reg[LAST];
  assign bus.zero      = zero_reg[LAST];
  assign bus.parity    = parity_reg[LAST];
  assign bus.op_err    = err_reg[LAST];
  assign bus.txn_count = txn_count_reg;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe: the driver pushes the expected
// result on every acceptance, an independent monitor pops on every fire.
module tb_logic_unit_pipe;

  localparam int WIDTH  = 8;
  localparam int STAGES = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic_unit_pipe_if #(.WIDTH(WIDTH)) bus ();

  logic_unit_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [WIDTH-1:0] y;
    logic             zero;
    logic             parity;
    logic             err;
  } res_t;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    res_t             r;
  } stim_t;

  res_t  exp_q[$];
  stim_t stim_q[$];
  int total = 0;
  int bad = 0;
  int delivered = 0;
  int accepts = 0;

  function automatic res_t mk(input logic [WIDTH-1:0] y, input logic z,
                              input logic p, input logic e);
    res_t r;
    r.y = y; r.zero = z; r.parity = p; r.err = e;
    return r;
  endfunction

  // Reference behaviour of one transaction
  function automatic res_t model(input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b,
                                 input logic [2:0] op);
    res_t r;
    r.err = 1'b0;
    case (op)
      3'd0: r.y = a & b;
      3'd1: r.y = a | b;
      3'd2: r.y = ~b;
      3'd3: r.y = ~(a & b);
      3'd4: r.y = ~(a | b);
      3'd5: r.y = a ^ b;
      3'd6: r.y = ~(a ^ b);
      default: begin r.y = '0; r.err = 1'b1; end
    endcase
    r.zero   = (r.y == '0);
    r.parity = ^r.y;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Monitor: compare every fired result against the scoreboard, and check
  // that a stalled output holds still
  logic stall_prev;
  res_t held;
  always @(negedge clk) begin
    res_t cur;
    res_t e;
    cur = mk(bus.y, bus.zero, bus.parity, bus.op_err);
    if (rst) begin
      stall_prev <= 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid", {63'd0, bus.out_valid}, 64'd1);
        check("stall_data", {53'd0, cur}, {53'd0, held});
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output: got y=%0h with empty scoreboard", bus.y);
        end else begin
          e = exp_q.pop_front();
          check("result", {53'd0, cur}, {53'd0, e});
        end
        delivered++;
      end
      stall_prev <= bus.out_valid & ~bus.out_ready;
      held       <= cur;
    end
  end

  task automatic add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                     input logic [2:0] op, input res_t r);
    stim_t s;
    s.a = a; s.b = b; s.op = op; s.r = r;
    stim_q.push_back(s);
  endtask

  // Drive queued stimulus for a number of cycles.
  // ready_mode: 0 = out_ready low, 1 = high, 2 = random
  task automatic pump(input int cycles, input int ready_mode, input bit rand_valid);
    for (int c = 0; c < cycles; c++) begin
      if (stim_q.size() > 0 && (!rand_valid || ($urandom_range(0, 1) == 1))) begin
        bus.in_valid = 1'b1;
        bus.a        = stim_q[0].a;
        bus.b        = stim_q[0].b;
        bus.op       = stim_q[0].op;
      end else begin
        bus.in_valid = 1'b0;
      end
      if (ready_mode == 2) bus.out_ready = ($urandom_range(0, 1) == 1);
      else                 bus.out_ready = (ready_mode == 1);
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(stim_q[0].r);
        void'(stim_q.pop_front());
        accepts++;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    exp_q.delete();
    stim_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0;
    int del0;
    int k;
    int guard;
    int sat_acc;
    bit got;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.op        = '0;
    bus.out_ready = 1'b0;

    // Reset state, sampled between edges
    #12;
    check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("rst_y", {56'd0, bus.y}, 64'd0);
    check("rst_flags", {61'd0, bus.zero, bus.parity, bus.op_err}, 64'd0);
    check("rst_txn_count", {48'd0, bus.txn_count}, 64'd0);
    check("rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("release_in_ready", {63'd0, bus.in_ready}, 64'd1);
    @(posedge clk);
    #1;

    // Latency of a lone transaction through an empty pipe
    add(8'hF0, 8'h3C, 3'd0, mk(8'h30, 1'b0, 1'b0, 1'b0));
    pump(1, 1, 1'b0);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.out_valid && k < 20);
    check("latency", k, STAGES);
    @(posedge clk);
    #1;

    // All seven functions back to back on F0/3C
    do_reset();
    add(8'hF0, 8'h3C, 3'd0, mk(8'h30, 1'b0, 1'b0, 1'b0));
    add(8'hF0, 8'h3C, 3'd1, mk(8'hFC, 1'b0, 1'b0, 1'b0));
    add(8'hF0, 8'h3C, 3'd2, mk(8'hC3, 1'b0, 1'b0, 1'b0));
    add(8'hF0, 8'h3C, 3'd3, mk(8'hCF, 1'b0, 1'b0, 1'b0));
    add(8'hF0, 8'h3C, 3'd4, mk(8'h03, 1'b0, 1'b0, 1'b0));
    add(8'hF0, 8'h3C, 3'd5, mk(8'hCC, 1'b0, 1'b0, 1'b0));
    add(8'hF0, 8'h3C, 3'd6, mk(8'h33, 1'b0, 1'b0, 1'b0));
    acc0 = accepts;
    del0 = delivered;
    pump(7, 1, 1'b0);
    check("stream_accepts_7_cycles", accepts - acc0, 7);
    pump(STAGES + 2, 1, 1'b0);
    check("stream_delivered", delivered - del0, 7);
    check("stream_scoreboard_empty", exp_q.size(), 0);
    check("stream_txn_count", {48'd0, bus.txn_count}, 64'd7);

    // Illegal op, flag corner cases, NOT b ignoring a
    add(8'hFF, 8'hFF, 3'd7, mk(8'h00, 1'b1, 1'b0, 1'b1));
    add(8'hFF, 8'h0F, 3'd0, mk(8'h0F, 1'b0, 1'b0, 1'b0));
    add(8'h01, 8'h00, 3'd5, mk(8'h01, 1'b0, 1'b1, 1'b0));
    add(8'h0F, 8'hF0, 3'd0, mk(8'h00, 1'b1, 1'b0, 1'b0));
    add(8'hAA, 8'h55, 3'd6, mk(8'h00, 1'b1, 1'b0, 1'b0));
    add(8'hFF, 8'h80, 3'd2, mk(8'h7F, 1'b0, 1'b1, 1'b0));
    del0 = delivered;
    pump(6 + STAGES + 2, 1, 1'b0);
    check("flags_delivered", delivered - del0, 6);
    check("flags_txn_count", {48'd0, bus.txn_count}, 64'd13);

    // Backpressure: only STAGES transactions fit while the consumer stalls
    do_reset();
    add(8'h11, 8'h22, 3'd1, mk(8'h33, 1'b0, 1'b0, 1'b0));
    add(8'h11, 8'h22, 3'd5, mk(8'h33, 1'b0, 1'b0, 1'b0));
    add(8'hF0, 8'hFF, 3'd0, mk(8'hF0, 1'b0, 1'b0, 1'b0));
    add(8'h00, 8'h01, 3'd4, mk(8'hFE, 1'b0, 1'b1, 1'b0));
    add(8'h0C, 8'h0A, 3'd3, mk(8'hF7, 1'b0, 1'b1, 1'b0));
    acc0 = accepts;
    del0 = delivered;
    pump(8, 0, 1'b0);
    check("bp_accepts_stalled", accepts - acc0, STAGES);
    check("bp_in_ready_low", {63'd0, bus.in_ready}, 64'd0);
    check("bp_none_delivered", delivered - del0, 0);
    pump(6 + STAGES + 2, 1, 1'b0);
    check("bp_accepts_total", accepts - acc0, 5);
    check("bp_delivered", delivered - del0, 5);
    check("bp_scoreboard_empty", exp_q.size(), 0);

    // Random traffic with random valid and ready
    do_reset();
    for (int i = 0; i < 1000; i++) begin
      logic [WIDTH-1:0] ra;
      logic [WIDTH-1:0] rb;
      logic [2:0]       rop;
      ra  = WIDTH'($urandom);
      rb  = WIDTH'($urandom);
      rop = 3'($urandom_range(0, 7));
      add(ra, rb, rop, model(ra, rb, rop));
    end
    acc0 = accepts;
    del0 = delivered;
    guard = 0;
    while (stim_q.size() > 0 && guard < 20000) begin
      pump(1, 2, 1'b1);
      guard++;
    end
    check("rand_no_timeout", {63'd0, (stim_q.size() == 0)}, 64'd1);
    pump(STAGES + 4, 1, 1'b0);
    check("rand_delivered", delivered - del0, 1000);
    check("rand_scoreboard_empty", exp_q.size(), 0);
    check("rand_txn_count", {48'd0, bus.txn_count}, 64'(accepts - acc0));

    // Asynchronous reset between edges with a full pipe
    do_reset();
    for (int i = 0; i < 4; i++) begin
      add(8'hF0, 8'h0F, 3'd1, mk(8'hFF, 1'b0, 1'b0, 1'b0));
    end
    pump(4, 0, 1'b0);
    check("pre_rst_full", {63'd0, bus.out_valid}, 64'd1);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("async_rst_y", {56'd0, bus.y}, 64'd0);
    check("async_rst_flags", {61'd0, bus.zero, bus.parity, bus.op_err}, 64'd0);
    check("async_rst_txn_count", {48'd0, bus.txn_count}, 64'd0);
    check("async_rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
    exp_q.delete();
    stim_q.delete();
    @(posedge clk);
    #1;
    check("rst_held_in_ready", {63'd0, bus.in_ready}, 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    del0 = delivered;
    pump(4, 1, 1'b0);
    check("post_rst_no_output", delivered - del0, 0);

    // Saturating transaction counter
    do_reset();
    sat_acc = 0;
    bus.out_ready = 1'b1;
    while (sat_acc < 65537) begin
      bus.in_valid = 1'b1;
      bus.a  = WIDTH'(sat_acc);
      bus.b  = WIDTH'(sat_acc >> 8);
      bus.op = 3'(sat_acc % 7);
      @(negedge clk);
      got = bus.in_ready;
      if (got) exp_q.push_back(model(bus.a, bus.b, bus.op));
      @(posedge clk);
      #1;
      if (got) begin
        sat_acc++;
        if (sat_acc == 65534) check("sat_fffe", {48'd0, bus.txn_count}, 64'hFFFE);
        if (sat_acc == 65535) check("sat_ffff", {48'd0, bus.txn_count}, 64'hFFFF);
        if (sat_acc == 65537) check("sat_hold", {48'd0, bus.txn_count}, 64'hFFFF);
      end
    end
    bus.in_valid = 1'b0;
    pump(STAGES + 2, 1, 1'b0);
    check("sat_scoreboard_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/logic_unit_pipe.md
# logic_unit_pipe

Parametrised, pipelined bitwise logic unit. Each transaction applies one of seven two-input logic functions (AND, OR, NOT, NAND, NOR, XOR, XNOR) across WIDTH-bit operands and returns the result with zero/parity flags. Transactions flow through a configurable number of register stages with valid/ready backpressure. It is the registered, multi-bit, handshaked successor to the single-bit combinational gate block, and sits between an operand source and a result consumer in datapath test fixtures.

## Interface
- WIDTH, 8, operand/result width in bits (1..64)
- STAGES, 2, pipeline register stages (1..4); also the unstalled latency in cycles
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  source presents a transaction
- in_ready  output  1  unit accepts a transaction this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- op  input  3  function select: 0 AND, 1 OR, 2 NOT b, 3 NAND, 4 NOR, 5 XOR, 6 XNOR, 7 illegal
- out_valid  output  1  result present at output stage
- out_ready  input  1  consumer accepts result this cycle
- y  output  WIDTH  result
- zero  output  1  y == 0
- parity  output  1  XOR-reduction of y
- op_err  output  1  result came from op == 7
- txn_count  output  16  accepted transactions, saturating at 16'hFFFF

## Operation
- Clock is clk; reset is rst, asynchronous and active-high. Single clock domain.
- Accept on in_valid & in_ready; fire on out_valid & out_ready.
- Function evaluated combinationally at input, then captured into stage 0. Stage k holds {valid, y, zero, parity, op_err}; output ports reflect stage STAGES-1.
- NOT b ignores a. op == 7: y = 0, zero = 1, parity = 0, op_err = 1; transaction still counted and delivered.
- Stage advance rule: stage k loads from stage k-1 when stage k is empty or stage k itself advances this cycle; last stage advances when out_ready. Chained backpressure, no bubbles: full throughput of one transaction per cycle while out_ready stays high.
- in_ready = ~rst & (~valid[0] | advance[0]); combinational from out_ready through the stage chain.
- Stalled stages hold data and flags unchanged; no transaction dropped or duplicated.
- A stage emptied without refill clears its valid bit; its data may hold stale values, but y/zero/parity/op_err are reported only under out_valid.
- txn_count increments by 1 per acceptance; holds at 16'hFFFF.

## Timing
- Reset (async assert): all stage valid bits 0, out_valid 0, y 0, zero 0, parity 0, op_err 0, txn_count 0, in_ready 0 while rst high.
- First cycle after rst deasserts: in_ready 1.
- Latency: transaction accepted at edge n appears with out_valid at edge n+STAGES-1 (visible after that edge; STAGES register delays from input to output).
- Stall: with out_ready low, pipeline fills; in_ready drops in the cycle all STAGES stages are valid and the last is not firing.
- Simultaneous fire and accept on a full pipe: both occur; occupancy unchanged.
- Reset mid-operation: all in-flight transactions discarded immediately; no out_valid until new input.
- out_valid/y may not change while out_valid & ~out_ready.

## Test plan
- WIDTH=8, STAGES=2: a=8'hF0, b=8'h3C, op 0..6 back-to-back, out_ready=1 -> y = 30, FC, C3, CF, 03, CC, 33 in order, one per cycle, first result 2 cycles after first accept; parity of 8'h30 = 0, 8'hFC = 0; txn_count = 7.
- op=7 with a=8'hFF, b=8'hFF -> y=0, zero=1, parity=0, op_err=1; next op=0 transaction has op_err=0.
- Backpressure: out_ready=0, stream 5 transactions -> exactly 2 accepted, in_ready=0; raise out_ready -> remaining 3 accepted, all 5 delivered in order, no duplicates.
- Random out_ready/in_valid over 1000 transactions vs scoreboard model, STAGES in {1,4}, WIDTH in {1,32} -> all results match in order; txn_count equals accepts.
- Assert rst asynchronously between clock edges with full pipe -> out_valid, y, flags, txn_count to 0 immediately; in_ready 0 during reset, 1 the cycle after release.
- Force txn_count to 16'hFFFE path (65537 accepts) -> holds at 16'hFFFF.
